apb_master: RTL

// - APB requester (initiator). Converts single-word commands from a local valid/ready port

---
 rtl/apb_master.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command at a time into a SETUP/ACCESS transfer
// and returns a one-cycle response. Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int AWIDTH         = 8,
  parameter int DWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   timeout;

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready are both high;
  // cmd_* are captured only then. Responses have no backpressure: rsp_valid is a single-cycle pulse.
  assign cmd_ready = (state == IDLE) | ((state == ACCESS) & PREADY);
  assign dbg_state = state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that sees PREADY low.
  assign timeout = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // No abort path: ACCESS waits for PREADY indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PWRITE <= cmd_write;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PENABLE   <= 1'b0;
            if (cmd_valid) begin
              // Back-to-back: PSEL stays high straight into the next SETUP.
              PADDR  <= cmd_addr;
              PWDATA <= cmd_wdata;
              PWRITE <= cmd_write;
              state  <= SETUP;
            end else begin
              PSEL  <= 1'b0;
              state <= IDLE;
            end
          end else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
